// File: rtl/video_timing_monitor_if.sv
// Video timing bundle: sync/blank inputs from the generator side and the
// recovered position, geometry and status reported by the monitor.
interface video_timing_monitor_if #(
    parameter int unsigned CW = 10
);
    logic          pxl_cen;
    logic          hsync;
    logic          vsync;
    logic          lhbl;
    logic          lvbl;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic [CW-1:0] h_total;
    logic [CW-1:0] h_active;
    logic [CW-1:0] hs_start;
    logic [CW-1:0] hs_end;
    logic [CW-1:0] v_total;
    logic [CW-1:0] v_active;
    logic [CW-1:0] vs_start;
    logic [CW-1:0] vs_end;
    logic          frame_stb;
    logic          locked;
    logic          mismatch;
    logic          sig_lost;

    modport master (
        output pxl_cen, hsync, vsync, lhbl, lvbl,
        input  hcnt, vcnt, h_total, h_active, hs_start, hs_end,
        input  v_total, v_active, vs_start, vs_end,
        input  frame_stb, locked, mismatch, sig_lost
    );

    modport slave (
        input  pxl_cen, hsync, vsync, lhbl, lvbl,
        output hcnt, vcnt, h_total, h_active, hs_start, hs_end,
        output v_total, v_active, vs_start, vs_end,
        output frame_stb, locked, mismatch, sig_lost
    );
endinterface

// File: rtl/video_timing_monitor.sv
// Recovers pixel/line position from HS/VS/LHBL/LVBL, measures line and frame
// geometry, and declares lock after LOCK_FRAMES matching frames.
module video_timing_monitor #(
    parameter int unsigned CW          = 10,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    video_timing_monitor_if.slave vif
);
    localparam int unsigned   MW        = 4;
    localparam int unsigned   SW        = 4 * CW;
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [MW-1:0] MATCH_MAX = '1;
    localparam logic [MW-1:0] LOCK_N    = MW'(LOCK_FRAMES);

    typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_CHECK, ST_LOCKED} state_t;

    state_t        state_q, state_d;
    logic [MW-1:0] match_q, match_d;
    logic          prev_lhbl_q, prev_lhbl_d;
    logic          prev_hs_q, prev_hs_d;
    logic          prev_vs_q, prev_vs_d;
    logic          line_lvbl_q, line_lvbl_d;
    logic          frame_bad_q, frame_bad_d;
    logic [CW-1:0] p_q, p_d, l_q, l_d;
    logic [CW-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
    logic [CW-1:0] hs_start_q, hs_start_d, hs_end_q, hs_end_d;
    logic [CW-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
    logic [CW-1:0] vs_start_q, vs_start_d, vs_end_q, vs_end_d;
    logic [SW-1:0] snap_q, snap_d;
    logic          frame_stb_q, frame_stb_d;
    logic          mismatch_q, mismatch_d;
    logic          locked_q, locked_d;
    logic          sig_lost_q, sig_lost_d;

    logic          ls, fs, loss, frame_match;
    logic [CW-1:0] p_inc, l_inc;

    assign p_inc = (p_q == CNT_MAX) ? p_q : p_q + CW'(1);
    assign l_inc = (l_q == CNT_MAX) ? l_q : l_q + CW'(1);

    // Position recovery, edge captures, line stability and loss detection.
    always_comb begin
        prev_lhbl_d = prev_lhbl_q;
        prev_hs_d   = prev_hs_q;
        prev_vs_d   = prev_vs_q;
        line_lvbl_d = line_lvbl_q;
        frame_bad_d = frame_bad_q;
        p_d         = p_q;
        l_d         = l_q;
        h_total_d   = h_total_q;
        h_active_d  = h_active_q;
        hs_start_d  = hs_start_q;
        hs_end_d    = hs_end_q;
        v_total_d   = v_total_q;
        v_active_d  = v_active_q;
        vs_start_d  = vs_start_q;
        vs_end_d    = vs_end_q;
        snap_d      = snap_q;
        sig_lost_d  = sig_lost_q;
        frame_stb_d = 1'b0;
        ls          = 1'b0;
        fs          = 1'b0;
        loss        = 1'b0;
        frame_match = 1'b0;
        if (vif.pxl_cen) begin
            ls          = vif.lhbl & ~prev_lhbl_q;
            fs          = ls & vif.lvbl & ~line_lvbl_q;
            prev_lhbl_d = vif.lhbl;
            prev_hs_d   = vif.hsync;
            p_d         = ls ? '0 : p_inc;
            if (ls) begin
                line_lvbl_d = vif.lvbl;
                prev_vs_d   = vif.vsync;
                l_d         = fs ? '0 : l_inc;
                h_total_d   = p_inc;
                sig_lost_d  = 1'b0;
                if (!fs && (p_inc != h_total_q)) frame_bad_d = 1'b1;
                if (fs) v_total_d = l_inc;
                if (!vif.lvbl && line_lvbl_q) v_active_d = l_d;
                if (vif.vsync && !prev_vs_q) vs_start_d = l_d;
                if (!vif.vsync && prev_vs_q) vs_end_d = l_d;
            end
            if (!vif.lhbl && prev_lhbl_q) h_active_d = p_d;
            if (vif.hsync && !prev_hs_q) hs_start_d = p_d;
            if (!vif.hsync && prev_hs_q) hs_end_d = p_d;
            if (!ls && (p_d == CNT_MAX)) begin
                loss       = 1'b1;
                sig_lost_d = 1'b1;
            end
            if (fs) begin
                frame_stb_d = 1'b1;
                frame_bad_d = 1'b0;
                snap_d      = {h_total_d, h_active_d, v_total_d, v_active_d};
                frame_match = !frame_bad_q && (snap_d == snap_q);
            end
        end
    end

    // Lock state machine, advanced at frame starts and reset by signal loss.
    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        mismatch_d = 1'b0;
        if (fs) begin
            case (state_q)
                ST_SEARCH:  state_d = ST_MEASURE;
                ST_MEASURE: begin
                    state_d = ST_CHECK;
                    match_d = '0;
                end
                default: begin
                    if (frame_match) begin
                        match_d = (match_q == MATCH_MAX) ? match_q : match_q + MW'(1);
                        if (match_d >= LOCK_N) state_d = ST_LOCKED;
                    end else begin
                        mismatch_d = 1'b1;
                        match_d    = '0;
                        state_d    = ST_CHECK;
                    end
                end
            endcase
        end else if (loss) begin
            state_d = ST_SEARCH;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            match_q     <= '0;
            prev_lhbl_q <= 1'b1;
            prev_hs_q   <= 1'b1;
            prev_vs_q   <= 1'b1;
            line_lvbl_q <= 1'b1;
            frame_bad_q <= 1'b0;
            p_q         <= '0;
            l_q         <= '0;
            h_total_q   <= '0;
            h_active_q  <= '0;
            hs_start_q  <= '0;
            hs_end_q    <= '0;
            v_total_q   <= '0;
            v_active_q  <= '0;
            vs_start_q  <= '0;
            vs_end_q    <= '0;
            snap_q      <= '0;
            frame_stb_q <= 1'b0;
            mismatch_q  <= 1'b0;
            locked_q    <= 1'b0;
            sig_lost_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            prev_lhbl_q <= prev_lhbl_d;
            prev_hs_q   <= prev_hs_d;
            prev_vs_q   <= prev_vs_d;
            line_lvbl_q <= line_lvbl_d;
            frame_bad_q <= frame_bad_d;
            p_q         <= p_d;
            l_q         <= l_d;
            h_total_q   <= h_total_d;
            h_active_q  <= h_active_d;
            hs_start_q  <= hs_start_d;
            hs_end_q    <= hs_end_d;
            v_total_q   <= v_total_d;
            v_active_q  <= v_active_d;
            vs_start_q  <= vs_start_d;
            vs_end_q    <= vs_end_d;
            snap_q      <= snap_d;
            frame_stb_q <= frame_stb_d;
            mismatch_q  <= mismatch_d;
            locked_q    <= locked_d;
            sig_lost_q  <= sig_lost_d;
        end
    end

    assign vif.hcnt      = p_q;
    assign vif.vcnt      = l_q;
    assign vif.h_total   = h_total_q;
    assign vif.h_active  = h_active_q;
    assign vif.hs_start  = hs_start_q;
    assign vif.hs_end    = hs_end_q;
    assign vif.v_total   = v_total_q;
    assign vif.v_active  = v_active_q;
    assign vif.vs_start  = vs_start_q;
    assign vif.vs_end    = vs_end_q;
    assign vif.frame_stb = frame_stb_q;
    assign vif.mismatch  = mismatch_q;
    assign vif.locked    = locked_q;
    assign vif.sig_lost  = sig_lost_q;
endmodule

// File: tb/tb_video_timing_monitor.sv
// Directed bench for video_timing_monitor on a compact frame geometry.
module tb_video_timing_monitor;
    localparam int unsigned CW = 10;
    localparam int H_TOT = 48;
    localparam int H_ACT = 32;
    localparam int HS0   = 36;
    localparam int HS1   = 40;
    localparam int V_TOT = 20;
    localparam int V_ACT = 15;
    localparam int VS0   = 16;
    localparam int VS1   = 18;
    localparam int NONE  = 1 << 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   div   = 4;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   fs_cnt = 0, mm_cnt = 0, lock_fs = 0, unlock_fs = 0;
    int   base_fs = 0, base_mm = 0;
    logic lk_q = 1'b0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    video_timing_monitor_if #(.CW(CW)) vif ();

    video_timing_monitor #(.CW(CW), .LOCK_FRAMES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .vif   (vif)
    );

    always #5 clk = ~clk;

    // Event monitor: counts frame starts / mismatches and notes lock transitions.
    always @(posedge clk) begin
        #1;
        if (vif.frame_stb === 1'b1) fs_cnt++;
        if (vif.mismatch === 1'b1) mm_cnt++;
        if (vif.locked === 1'b1 && !lk_q) lock_fs = fs_cnt;
        if (vif.locked !== 1'b1 && lk_q) unlock_fs = fs_cnt;
        lk_q = (vif.locked === 1'b1);
    end

    task automatic px(input logic hs, input logic vs, input logic hb, input logic vb);
        vif.hsync   = hs;
        vif.vsync   = vs;
        vif.lhbl    = hb;
        vif.lvbl    = vb;
        vif.pxl_cen = 1'b1;
        @(negedge clk);
        vif.pxl_cen = 1'b0;
        for (int i = 1; i < div; i++) @(negedge clk);
    endtask

    task automatic drive_frame(input int stretch_ln, input int hs_ln, input int skip, input int limit);
        int n;
        int len;
        n = 0;
        for (int ln = 0; ln < V_TOT; ln++) begin
            len = (ln == stretch_ln) ? H_TOT + 1 : H_TOT;
            for (int s = 0; s < len; s++) begin
                if (n >= skip && n < limit)
                    px((ln >= hs_ln) ? (s < 4) : (s >= HS0 && s < HS1),
                       (ln >= VS0 && ln < VS1), (s < H_ACT), (ln < V_ACT));
                n++;
            end
        end
    endtask

    task automatic frames(input int cnt);
        for (int f = 0; f < cnt; f++) drive_frame(NONE, NONE, 0, NONE);
    endtask

    task automatic push(input string t, input int e);
        tag_q.push_back(t);
        exp_q.push_back(32'(e));
    endtask

    task automatic push_meas();
        push("h_total", H_TOT);
        push("h_active", H_ACT);
        push("hs_start", HS0);
        push("hs_end", HS1);
        push("v_total", V_TOT);
        push("v_active", V_ACT);
        push("vs_start", VS0);
        push("vs_end", VS1);
    endtask

    task automatic push_zero();
        push("hcnt", 0);     push("vcnt", 0);
        push("h_total", 0);  push("h_active", 0);
        push("hs_start", 0); push("hs_end", 0);
        push("v_total", 0);  push("v_active", 0);
        push("vs_start", 0); push("vs_end", 0);
        push("frame_stb", 0); push("locked", 0);
        push("mismatch", 0); push("sig_lost", 0);
    endtask

    function automatic logic [31:0] obs_of(input string t);
        case (t)
            "hcnt":      return 32'(vif.hcnt);
            "vcnt":      return 32'(vif.vcnt);
            "h_total":   return 32'(vif.h_total);
            "h_active":  return 32'(vif.h_active);
            "hs_start":  return 32'(vif.hs_start);
            "hs_end":    return 32'(vif.hs_end);
            "v_total":   return 32'(vif.v_total);
            "v_active":  return 32'(vif.v_active);
            "vs_start":  return 32'(vif.vs_start);
            "vs_end":    return 32'(vif.vs_end);
            "frame_stb": return 32'(vif.frame_stb);
            "locked":    return 32'(vif.locked);
            "mismatch":  return 32'(vif.mismatch);
            "sig_lost":  return 32'(vif.sig_lost);
            "lock_at":   return 32'(lock_fs - base_fs);
            "unlock_at": return 32'(unlock_fs - base_fs);
            "mm_cnt":    return 32'(mm_cnt - base_mm);
            default:     return 32'hdead_beef;
        endcase
    endfunction

    // Pops every pending expectation and compares it with the DUT now.
    task automatic drain(input string phase);
        string       t;
        logic [31:0] e;
        logic [31:0] o;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            o = obs_of(t);
            n_tests++;
            assert (o === e) else begin
                n_fail++;
                $error("FAIL %s/%s: observed %0d expected %0d", phase, t, o, e);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        base_fs = fs_cnt;
        base_mm = mm_cnt;
    endtask

    initial begin
        vif.pxl_cen = 1'b0;
        vif.hsync   = 1'b0;
        vif.vsync   = 1'b0;
        vif.lhbl    = 1'b1;
        vif.lvbl    = 1'b1;

        // Reset state
        #1;
        push_zero();
        drain("reset");
        do_reset();

        // Nominal timing, pxl_cen every 4th clk
        div = 4;
        push_meas();
        push("hcnt", H_TOT - 1);
        push("vcnt", V_TOT - 1);
        push("locked", 0);
        frames(3);
        drain("nominal_meas");
        push("lock_at", 4);
        push("mm_cnt", 0);
        push("locked", 1);
        frames(2);
        drain("nominal_lock");

        // Same timing with pxl_cen always high
        do_reset();
        div = 1;
        push_meas();
        push("lock_at", 4);
        push("mm_cnt", 0);
        push("locked", 1);
        frames(5);
        drain("fullrate");

        // One stretched line while locked
        base_fs = fs_cnt;
        base_mm = mm_cnt;
        push("mm_cnt", 1);
        push("unlock_at", 2);
        push("lock_at", 4);
        push("locked", 1);
        push("h_total", H_TOT);
        drive_frame(5, NONE, 0, NONE);
        frames(3);
        drain("stretch");

        // Blanking held low: saturation boundary and loss
        for (int k = 0; k < 1023 - H_TOT; k++) px(1'b0, 1'b0, 1'b0, 1'b0);
        push("hcnt", 1022);
        push("sig_lost", 0);
        push("locked", 1);
        drain("loss_pre");
        px(1'b0, 1'b0, 1'b0, 1'b0);
        push("hcnt", 1023);
        push("sig_lost", 1);
        push("locked", 0);
        drain("loss");

        // Resume input: first line start clears loss and starts a frame
        base_fs = fs_cnt;
        base_mm = mm_cnt;
        px(1'b0, 1'b0, 1'b1, 1'b1);
        push("sig_lost", 0);
        push("frame_stb", 1);
        push("hcnt", 0);
        push("vcnt", 0);
        push("h_total", 1023);
        drain("resume_ls");
        push("lock_at", 4);
        push("locked", 1);
        push("mm_cnt", 0);
        drive_frame(NONE, NONE, 1, NONE);
        frames(3);
        drain("resume_lock");

        // hsync rising on the line-start sample
        base_mm = mm_cnt;
        push("hs_start", 0);
        push("hs_end", 4);
        push("locked", 1);
        push("mm_cnt", 0);
        drive_frame(NONE, 3, 0, NONE);
        drain("hs_on_ls");

        // Reset mid-frame while locked
        push("locked", 1);
        drive_frame(NONE, NONE, 0, 300);
        drain("pre_reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        push_zero();
        drain("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base_fs = fs_cnt;
        base_mm = mm_cnt;
        push_meas();
        push("lock_at", 4);
        push("mm_cnt", 0);
        push("locked", 1);
        frames(5);
        drain("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
